// File: rtl/ssd_display_arbiter_if.sv
// Requester-side bus of the seven-segment display arbiter: requests and words in,
// grant/owner status and the selected display word out.
interface ssd_display_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] data;
  logic [NUM_REQ-1:0]        grant;
  logic [2:0]                owner;
  logic [DATA_W-1:0]         encoded;
  logic                      busy;
  logic                      slot_done;

  modport master (
    output req, data,
    input  grant, owner, encoded, busy, slot_done
  );

  modport slave (
    input  req, data,
    output grant, owner, encoded, busy, slot_done
  );
endinterface

// File: rtl/ssd_display_arbiter.sv
// Round-robin time-slot arbiter sharing one 8-digit seven-segment display between requesters.
// Optional macro SSD_ARB_PRIORITY_EN: requester 0 preempts and holds with no dwell limit.
module ssd_display_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int DATA_W       = 32
) (
  input logic               Clk,
  input logic               Reset_n,
  ssd_display_arbiter_if.slave bus
);
  localparam int CNT_W = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [2:0]         rr, rr_n;
  logic [2:0]         owner, owner_n;
  logic [NUM_REQ-1:0] grant_q;
  logic [DATA_W-1:0]  encoded_q, enc_sel;
  logic               slot_done_q;
  logic               owner_req;
  logic [3:0]         pick_res;

  // Returns {found, index} of the first set request at or after start, wrapping.
  function automatic logic [3:0] pick(input logic [NUM_REQ-1:0] r, input logic [2:0] start);
    logic [3:0]         res;
    logic [NUM_REQ-1:0] r_sh;
    int unsigned        k;
    res = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = 32'(start) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      r_sh = r >> k;
      if (!res[3] && r_sh[0]) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] x);
    return (int'(x) == NUM_REQ - 1) ? 3'd0 : x + 3'd1;
  endfunction

  always_comb begin
    logic [NUM_REQ-1:0]        req_sh;
    logic [NUM_REQ*DATA_W-1:0] data_sh;
    req_sh    = bus.req >> owner;
    owner_req = req_sh[0];
    enc_sel   = '0;
    data_sh   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner == 3'(k)) begin
        data_sh = bus.data >> (k * DATA_W);
        enc_sel = data_sh[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rr_n     = rr;
    owner_n  = owner;
    pick_res = '0;
    if (state == IDLE) begin
      pick_res = pick(bus.req, rr);
`ifdef SSD_ARB_PRIORITY_EN
      if (bus.req[0]) pick_res = {1'b1, 3'd0};
`endif
      if (pick_res[3]) begin
        state_n = HOLD;
        owner_n = pick_res[2:0];
        cnt_n   = '0;
      end
    end else begin
      cnt_n = cnt + 1'b1;
      // Expiry wins over a same-cycle release, so both share this path.
      if (!owner_req || cnt == CNT_LAST) begin
        rr_n     = wrap_inc(owner);
        pick_res = pick(bus.req, wrap_inc(owner));
        cnt_n    = '0;
        if (pick_res[3]) owner_n = pick_res[2:0];
        else             state_n = IDLE;
      end
`ifdef SSD_ARB_PRIORITY_EN
      // Priority owner: no dwell limit, and the round-robin pointer is left untouched.
      if (owner == 3'd0) begin
        rr_n    = rr;
        cnt_n   = '0;
        owner_n = 3'd0;
        state_n = HOLD;
        if (!bus.req[0]) begin
          pick_res = pick(bus.req, rr);
          if (pick_res[3]) owner_n = pick_res[2:0];
          else             state_n = IDLE;
        end
      end else if (bus.req[0]) begin
        rr_n    = rr;
        cnt_n   = '0;
        owner_n = 3'd0;
        state_n = HOLD;
      end
`endif
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rr          <= '0;
      owner       <= '0;
      grant_q     <= '0;
      encoded_q   <= '0;
      slot_done_q <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      rr          <= rr_n;
      owner       <= owner_n;
      grant_q     <= (state_n == HOLD) ? (NUM_REQ'(1) << owner_n) : '0;
      encoded_q   <= (state == HOLD && state_n == HOLD) ? enc_sel : '0;
      // Pulse is aligned with the last cycle of the slot, not the one after it.
      slot_done_q <= (state_n == HOLD) && (cnt_n == CNT_LAST);
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner;
  assign bus.encoded   = encoded_q;
  assign bus.busy      = (state == HOLD);
  assign bus.slot_done = slot_done_q;
endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Self-checking bench for ssd_display_arbiter: directed scenarios plus randomized
// request/data traffic compared against a slot-level reference model.
module tb_ssd_display_arbiter;
  localparam int NREQ  = 4;
  localparam int DWELL = 4;
  localparam int DW    = 32;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  ssd_display_arbiter_if #(.NUM_REQ(NREQ), .DATA_W(DW)) bus ();

  ssd_display_arbiter #(.NUM_REQ(NREQ), .DWELL_CYCLES(DWELL), .DATA_W(DW)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the display, for how long, and where the next search starts.
  logic        m_busy;
  int          m_owner;
  int          m_age;
  int          m_rr;
  logic [31:0] m_enc;

  function automatic int first_req(input logic [NREQ-1:0] r, input int start);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(start + i) % NREQ]) return (start + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_grant();
    return m_busy ? (NREQ'(1) << m_owner) : '0;
  endfunction

  function automatic logic exp_slot();
    return m_busy && (m_age == DWELL - 1);
  endfunction

  task automatic m_reset();
    m_busy = 1'b0; m_owner = 0; m_age = 0; m_rr = 0; m_enc = '0;
  endtask

  task automatic m_step();
    logic [NREQ-1:0] r;
    logic [31:0]     d;
    logic            was_busy;
    int              idx;
    r        = bus.req;
    d        = bus.data[m_owner*DW +: DW];
    was_busy = m_busy;
    if (!m_busy) begin
      idx = first_req(r, m_rr);
`ifdef SSD_ARB_PRIORITY_EN
      if (r[0]) idx = 0;
`endif
      if (idx >= 0) begin m_busy = 1'b1; m_owner = idx; m_age = 0; end
    end
`ifdef SSD_ARB_PRIORITY_EN
    else if (m_owner == 0) begin
      if (!r[0]) begin
        idx = first_req(r, m_rr);
        if (idx >= 0) begin m_owner = idx; m_age = 0; end
        else m_busy = 1'b0;
      end
    end else if (r[0]) begin
      m_owner = 0; m_age = 0;
    end
`endif
    else if (m_age == DWELL - 1 || !r[m_owner]) begin
      m_rr = (m_owner + 1) % NREQ;
      idx  = first_req(r, m_rr);
      if (idx >= 0) begin m_owner = idx; m_age = 0; end
      else m_busy = 1'b0;
    end else begin
      m_age++;
    end
    m_enc = (was_busy && m_busy) ? d : '0;
  endtask

  // Advance model and DUT by one clock; outputs are then sampled at the falling edge.
  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    bus.req  = '0;
    bus.data = '0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.encoded !== 32'h0 ||
          bus.slot_done !== 1'b0 || bus.owner !== 3'd0) begin
        failures++;
        $display("FAIL reset_state cyc=%0d got grant=%b busy=%b enc=%h sd=%b owner=%0d exp all zero",
                 i, bus.grant, bus.busy, bus.encoded, bus.slot_done, bus.owner);
      end
    end
    rst_n = 1'b1;
    m_reset();
    tick();
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.encoded !== 32'h0) begin
      failures++;
      $display("FAIL idle_after_reset got grant=%b busy=%b enc=%h exp 0/0/0",
               bus.grant, bus.busy, bus.encoded);
    end
  endtask

  task automatic test_single();
    int pulses;
    bus.data = {$urandom, $urandom, 32'h01234567, $urandom};
    bus.req  = 4'b0010;
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.busy !== 1'b1 || bus.owner !== 3'd1) begin
      failures++;
      $display("FAIL single_grant got grant=%b busy=%b owner=%0d exp 0010/1/1",
               bus.grant, bus.busy, bus.owner);
    end
    checks++;
    if (bus.encoded !== 32'h0) begin
      failures++;
      $display("FAIL single_enc_latency got=%h exp=00000000", bus.encoded);
    end
    tick();
    checks++;
    if (bus.encoded !== 32'h01234567) begin
      failures++;
      $display("FAIL single_encoded got=%h exp=01234567", bus.encoded);
    end
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.slot_done === 1'b1) pulses++;
      checks++;
      if (bus.grant !== 4'b0010 || bus.slot_done !== exp_slot()) begin
        failures++;
        $display("FAIL single_hold cyc=%0d got grant=%b sd=%b exp grant=0010 sd=%b",
                 i, bus.grant, bus.slot_done, exp_slot());
      end
    end
    checks++;
    if (pulses != 3) begin
      failures++;
      $display("FAIL single_pulse_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_round_robin();
    int seq [3] = '{0, 1, 3};
    do_reset();
    bus.req = 4'b1011;
    for (int i = 0; i < 24; i++) begin
      bus.data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (bus.busy !== 1'b1 || bus.owner !== 3'(seq[(i / DWELL) % 3]) ||
          bus.grant !== (NREQ'(1) << seq[(i / DWELL) % 3])) begin
        failures++;
        $display("FAIL rr_owner cyc=%0d got owner=%0d grant=%b busy=%b exp owner=%0d",
                 i, bus.owner, bus.grant, bus.busy, seq[(i / DWELL) % 3]);
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req = 4'b0110;
    tick();
    tick();
    checks++;
    if (bus.grant !== 4'b0010) begin
      failures++;
      $display("FAIL early_pre got grant=%b exp=0010", bus.grant);
    end
    bus.req = 4'b0100;
    tick();
    checks++;
    if (bus.grant !== 4'b0100 || bus.slot_done !== 1'b0 || bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL early_release got grant=%b sd=%b busy=%b exp 0100/0/1",
               bus.grant, bus.slot_done, bus.busy);
    end
    tick();
    checks++;
    if (bus.slot_done !== 1'b0 || bus.grant !== 4'b0100) begin
      failures++;
      $display("FAIL early_after got sd=%b grant=%b exp 0/0100", bus.slot_done, bus.grant);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.req = 4'b1000;
    tick();
    tick();
    checks++;
    if (bus.owner !== 3'd3) begin
      failures++;
      $display("FAIL midrst_pre got owner=%0d exp=3", bus.owner);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0 || bus.encoded !== 32'h0) begin
      failures++;
      $display("FAIL midrst_async got grant=%b busy=%b enc=%h exp 0/0/0",
               bus.grant, bus.busy, bus.encoded);
    end
    bus.req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.owner !== 3'd0) begin
      failures++;
      $display("FAIL midrst_first got grant=%b owner=%0d exp 0001/0", bus.grant, bus.owner);
    end
  endtask

  task automatic test_random();
    do_reset();
    bus.req = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) bus.req = NREQ'($urandom);
      bus.data = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (bus.grant !== exp_grant() || bus.busy !== m_busy) begin
        failures++;
        $display("FAIL rand_grant cyc=%0d got grant=%b busy=%b exp grant=%b busy=%b",
                 i, bus.grant, bus.busy, exp_grant(), m_busy);
      end
      if (m_busy) begin
        checks++;
        if (bus.owner !== 3'(m_owner)) begin
          failures++;
          $display("FAIL rand_owner cyc=%0d got=%0d exp=%0d", i, bus.owner, m_owner);
        end
      end
      checks++;
      if (bus.encoded !== m_enc) begin
        failures++;
        $display("FAIL rand_encoded cyc=%0d got=%h exp=%h", i, bus.encoded, m_enc);
      end
      checks++;
      if (bus.slot_done !== exp_slot()) begin
        failures++;
        $display("FAIL rand_slot_done cyc=%0d got=%b exp=%b", i, bus.slot_done, exp_slot());
      end
    end
  endtask

`ifdef SSD_ARB_PRIORITY_EN
  task automatic test_priority();
    do_reset();
    bus.req = 4'b0100;
    for (int i = 0; i < DWELL + 1; i++) tick();
    checks++;
    if (bus.grant !== 4'b0100) begin
      failures++;
      $display("FAIL prio_pre got grant=%b exp=0100", bus.grant);
    end
    bus.req = 4'b1101;
    tick();
    checks++;
    if (bus.grant !== 4'b0001 || bus.slot_done !== 1'b0) begin
      failures++;
      $display("FAIL prio_preempt got grant=%b sd=%b exp 0001/0", bus.grant, bus.slot_done);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.grant !== 4'b0001 || bus.slot_done !== 1'b0) begin
        failures++;
        $display("FAIL prio_hold cyc=%0d got grant=%b sd=%b exp 0001/0", i, bus.grant, bus.slot_done);
      end
    end
    bus.req = 4'b1100;
    tick();
    checks++;
    if (bus.grant !== 4'b1000) begin
      failures++;
      $display("FAIL prio_resume got grant=%b exp=1000", bus.grant);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b1;
    m_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_mid_reset();
`ifdef SSD_ARB_PRIORITY_EN
    test_priority();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench did not complete");
  end
endmodule
